// File: rtl/spi_flash_responder_pkg.sv
// Shared opcodes and FSM state encoding for the SPI flash responder.
package spi_flash_pkg;

  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_RDID = 8'h9F;
  localparam logic [7:0] OP_RDSR = 8'h05;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    ID,
    STAT,
    IGNORE
  } flash_state_e;

endpackage

// File: rtl/spi_flash_responder_if.sv
// SPI pins plus the byte-wide backing-memory port of the flash responder.
interface spi_flash_responder_if #(
  parameter int MEM_ADDR_W = 16
);
  logic                  spi_sclk_i;
  logic                  spi_cs_n_i;
  logic                  spi_mosi_i;
  logic                  spi_miso_o;
  logic                  spi_miso_oe_o;
  logic                  mem_rd_o;
  logic [MEM_ADDR_W-1:0] mem_addr_o;
  logic [7:0]            mem_rdata_i;
  logic                  busy_o;

  modport slave (
    input  spi_sclk_i, spi_cs_n_i, spi_mosi_i, mem_rdata_i,
    output spi_miso_o, spi_miso_oe_o, mem_rd_o, mem_addr_o, busy_o
  );

  modport master (
    output spi_sclk_i, spi_cs_n_i, spi_mosi_i, mem_rdata_i,
    input  spi_miso_o, spi_miso_oe_o, mem_rd_o, mem_addr_o, busy_o
  );
endinterface

// File: rtl/spi_flash_responder_sync_edge.sv
// Multi-flop synchronizer with single-cycle rise/fall pulses taken from the
// last two synchronized samples.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);
  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o =  sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] &  prev_q;
endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 NOR-flash responder: READ / RDID / RDSR served from a byte-wide
// memory port, all SPI pins oversampled in the clk domain.
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int          MEM_ADDR_W  = 16,
  parameter logic [23:0] JEDEC_ID    = 24'hEF4016,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  spi_flash_responder_if.slave   bus
);
  logic sclk_unused_q, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, mosi_unused_rise, mosi_unused_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .reset_n(reset_n), .d_i(bus.spi_sclk_i),
    .q_o(sclk_unused_q), .rise_o(sclk_rise), .fall_o(sclk_fall));

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .reset_n(reset_n), .d_i(bus.spi_cs_n_i),
    .q_o(cs_s), .rise_o(cs_rise), .fall_o(cs_fall));

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk(clk), .reset_n(reset_n), .d_i(bus.spi_mosi_i),
    .q_o(mosi_s), .rise_o(mosi_unused_rise), .fall_o(mosi_unused_fall));

  flash_state_e          state_q, state_d;
  logic [2:0]            bit_q, bit_d;
  logic [4:0]            acnt_q, acnt_d;
  logic [6:0]            cmd_q, cmd_d;
  logic [MEM_ADDR_W-2:0] ain_q, ain_d;
  logic [MEM_ADDR_W-1:0] addr_q, addr_d;
  logic                  rd_q, rd_d;
  logic                  pend_q, pend_d;
  logic [7:0]            buf_q, buf_d;
  logic [7:0]            tx_q, tx_d;
  logic [2:0]            txcnt_q, txcnt_d;
  logic                  oe_q, oe_d;
  logic [1:0]            idx_q, idx_d;
  logic [7:0]            id_byte;
  logic                  rise, fall;

  // sclk only matters while the synchronized chip select is asserted
  assign rise = sclk_rise & ~cs_s;
  assign fall = sclk_fall & ~cs_s;

  always_comb begin
    unique case (idx_q)
      2'd0:    id_byte = JEDEC_ID[23:16];
      2'd1:    id_byte = JEDEC_ID[15:8];
      default: id_byte = JEDEC_ID[7:0];
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      bit_q   <= '0;
      acnt_q  <= '0;
      cmd_q   <= '0;
      ain_q   <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      pend_q  <= 1'b0;
      buf_q   <= '0;
      tx_q    <= '0;
      txcnt_q <= '0;
      oe_q    <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      acnt_q  <= acnt_d;
      cmd_q   <= cmd_d;
      ain_q   <= ain_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      pend_q  <= pend_d;
      buf_q   <= buf_d;
      tx_q    <= tx_d;
      txcnt_q <= txcnt_d;
      oe_q    <= oe_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    acnt_d  = acnt_q;
    cmd_d   = cmd_q;
    ain_d   = ain_q;
    addr_d  = addr_q;
    rd_d    = 1'b0;
    pend_d  = rd_q;
    buf_d   = pend_q ? bus.mem_rdata_i : buf_q;
    tx_d    = tx_q;
    txcnt_d = txcnt_q;
    oe_d    = oe_q;
    idx_d   = idx_q;

    if (cs_rise) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      pend_d  = 1'b0;
      tx_d    = '0;
    end else begin
      unique case (state_q)
        IDLE: if (cs_fall) begin
          state_d = CMD;
          bit_d   = '0;
          acnt_d  = '0;
          txcnt_d = '0;
          idx_d   = '0;
          oe_d    = 1'b0;
        end
        CMD: if (rise) begin
          cmd_d = {cmd_q[5:0], mosi_s};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            unique case ({cmd_q, mosi_s})
              OP_READ: state_d = ADDR;
              OP_RDID: state_d = ID;
              OP_RDSR: state_d = STAT;
              default: state_d = IGNORE;
            endcase
          end
        end
        ADDR: if (rise) begin
          ain_d  = {ain_q[MEM_ADDR_W-3:0], mosi_s};
          acnt_d = acnt_q + 5'd1;
          if (acnt_q == 5'd23) begin
            addr_d  = {ain_q, mosi_s};
            rd_d    = 1'b1;
            state_d = DATA;
          end
        end
        // each byte load immediately prefetches the following address
        DATA: if (fall) begin
          oe_d    = 1'b1;
          txcnt_d = txcnt_q + 3'd1;
          if (txcnt_q == 3'd0) begin
            tx_d   = buf_q;
            addr_d = addr_q + 1'b1;
            rd_d   = 1'b1;
          end else begin
            tx_d = {tx_q[6:0], 1'b0};
          end
        end
        ID: if (fall) begin
          oe_d    = 1'b1;
          txcnt_d = txcnt_q + 3'd1;
          if (txcnt_q == 3'd0) begin
            tx_d  = id_byte;
            idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
          end else begin
            tx_d = {tx_q[6:0], 1'b0};
          end
        end
        STAT: if (fall) begin
          oe_d = 1'b1;
          tx_d = '0;
        end
        IGNORE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.spi_miso_o    = oe_q & tx_q[7];
  assign bus.spi_miso_oe_o = oe_q;
  assign bus.mem_rd_o      = rd_q;
  assign bus.mem_addr_o    = addr_q;
  assign bus.busy_o        = ~cs_s;
endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: a SPI master driving READ/RDID/RDSR
// against a memory holding mem[a] = a[7:0] ^ 8'hA5.
module tb_spi_flash_responder;
  localparam int HALF = 50;

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  int          rd_n = 0;
  logic [15:0] rd_arr [0:63];
  int          oe_hi = 0;
  int          miso_viol = 0;

  spi_flash_responder_if #(.MEM_ADDR_W(16)) bus ();

  spi_flash_responder #(
    .MEM_ADDR_W(16), .JEDEC_ID(24'hEF4016), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) bus.mem_rdata_i <= 8'h00;
    else if (bus.mem_rd_o) bus.mem_rdata_i <= bus.mem_addr_o[7:0] ^ 8'hA5;
  end

  always @(negedge clk) begin
    if (bus.mem_rd_o) begin
      rd_arr[rd_n & 63] <= bus.mem_addr_o;
      rd_n <= rd_n + 1;
    end
    if (bus.spi_miso_oe_o) oe_hi <= oe_hi + 1;
    if (!bus.spi_miso_oe_o && bus.spi_miso_o) miso_viol <= miso_viol + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [7:0] tx, input int nb, input bit last,
                      output logic [7:0] rx, output logic [7:0] oe);
    rx = '0;
    oe = '0;
    for (int i = 7; i >= 8 - nb; i--) begin
      bus.spi_mosi_i = tx[i];
      #HALF;
      bus.spi_sclk_i = 1'b1;
      rx[i] = bus.spi_miso_o;
      oe[i] = bus.spi_miso_oe_o;
      #HALF;
      if (last && i == 8 - nb) begin
        bus.spi_cs_n_i = 1'b1;
        #20;
      end
      bus.spi_sclk_i = 1'b0;
    end
  endtask

  task automatic start(input string tag);
    bus.spi_cs_n_i = 1'b0;
    repeat (8) @(negedge clk);
    chk({tag, "_busy"}, bus.busy_o, 1'b1);
  endtask

  task automatic send_read(input string tag, input logic [23:0] a);
    logic [7:0] rx, oe, oe_all;
    xfer(8'h03, 8, 1'b0, rx, oe);
    oe_all = oe;
    xfer(a[23:16], 8, 1'b0, rx, oe); oe_all |= oe;
    xfer(a[15:8],  8, 1'b0, rx, oe); oe_all |= oe;
    xfer(a[7:0],   8, 1'b0, rx, oe); oe_all |= oe;
    chk({tag, "_hdr_oe"}, oe_all, 8'h00);
  endtask

  task automatic finish_xact(input string tag);
    repeat (8) @(negedge clk);
    chk({tag, "_end_oe"}, bus.spi_miso_oe_o, 1'b0);
    chk({tag, "_end_busy"}, bus.busy_o, 1'b0);
  endtask

  task automatic chk_reads(input string tag, input int base, input int n, input logic [15:0] a0);
    logic [15:0] e;
    chk({tag, "_rd_cnt"}, rd_n - base, n);
    for (int k = 0; k < n; k++) begin
      e = a0 + 16'(k);
      chk({tag, "_rd_addr"}, rd_arr[(base + k) & 63], e);
    end
  endtask

  initial begin
    logic [7:0] rx, oe;
    logic [7:0] exp_id [0:5];
    logic [7:0] exp_w  [0:3];
    int base, oe0;

    exp_id = '{8'hEF, 8'h40, 8'h16, 8'hEF, 8'h40, 8'h16};
    exp_w  = '{8'h5B, 8'h5A, 8'hA5, 8'hA4};

    reset_n = 1'b0;
    bus.spi_cs_n_i = 1'b1;
    bus.spi_sclk_i = 1'b0;
    bus.spi_mosi_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_miso", bus.spi_miso_o, 1'b0);
    chk("rst_oe", bus.spi_miso_oe_o, 1'b0);
    chk("rst_rd", bus.mem_rd_o, 1'b0);
    chk("rst_addr", bus.mem_addr_o, 16'h0000);
    chk("rst_busy", bus.busy_o, 1'b0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // READ 0x000010, four bytes
    base = rd_n;
    start("rd");
    send_read("rd", 24'h000010);
    xfer(8'h00, 8, 1'b0, rx, oe); chk("rd_b0", rx, 8'hB5); chk("rd_b0_oe", oe, 8'hFF);
    xfer(8'h00, 8, 1'b0, rx, oe); chk("rd_b1", rx, 8'hB4);
    xfer(8'h00, 8, 1'b0, rx, oe); chk("rd_b2", rx, 8'hB7);
    xfer(8'h00, 8, 1'b1, rx, oe); chk("rd_b3", rx, 8'hB6); chk("rd_b3_oe", oe, 8'hFF);
    finish_xact("rd");
    chk_reads("rd", base, 5, 16'h0010);

    // JEDEC ID, six bytes, with first-bit latency check
    base = rd_n;
    start("id");
    xfer(8'h9F, 8, 1'b0, rx, oe); chk("id_cmd_oe", oe, 8'h00);
    #40;
    chk("id_lat_oe", bus.spi_miso_oe_o, 1'b1);
    chk("id_lat_miso", bus.spi_miso_o, 1'b1);
    for (int k = 0; k < 6; k++) begin
      xfer(8'h00, 8, k == 5, rx, oe);
      chk("id_byte", rx, exp_id[k]);
      chk("id_oe", oe, 8'hFF);
    end
    finish_xact("id");
    chk("id_no_rd", rd_n - base, 0);

    // READ STATUS, two bytes
    start("sr");
    xfer(8'h05, 8, 1'b0, rx, oe); chk("sr_cmd_oe", oe, 8'h00);
    xfer(8'h00, 8, 1'b0, rx, oe); chk("sr_b0", rx, 8'h00); chk("sr_b0_oe", oe, 8'hFF);
    xfer(8'h00, 8, 1'b1, rx, oe); chk("sr_b1", rx, 8'h00); chk("sr_b1_oe", oe, 8'hFF);
    finish_xact("sr");

    // READ across the 64 KiB wrap with upper address bits dropped
    base = rd_n;
    start("wr");
    send_read("wr", 24'h12FFFE);
    for (int k = 0; k < 4; k++) begin
      xfer(8'h00, 8, k == 3, rx, oe);
      chk("wr_byte", rx, exp_w[k]);
    end
    finish_xact("wr");
    chk_reads("wr", base, 5, 16'hFFFE);

    // abort mid-byte, then a clean restart
    base = rd_n;
    start("ab");
    send_read("ab", 24'h000010);
    xfer(8'h00, 8, 1'b0, rx, oe); chk("ab_b0", rx, 8'hB5);
    xfer(8'h00, 3, 1'b0, rx, oe); chk("ab_part", rx, 8'hA0);
    bus.spi_cs_n_i = 1'b1;
    repeat (10) @(negedge clk);
    chk("ab_gap_oe", bus.spi_miso_oe_o, 1'b0);
    chk("ab_gap_miso", bus.spi_miso_o, 1'b0);
    chk("ab_gap_busy", bus.busy_o, 1'b0);
    chk_reads("ab", base, 3, 16'h0010);
    base = rd_n;
    start("rs");
    send_read("rs", 24'h000000);
    xfer(8'h00, 8, 1'b0, rx, oe); chk("rs_b0", rx, 8'hA5); chk("rs_b0_oe", oe, 8'hFF);
    xfer(8'h00, 8, 1'b1, rx, oe); chk("rs_b1", rx, 8'hA4);
    finish_xact("rs");
    chk_reads("rs", base, 3, 16'h0000);

    // unsupported opcode: no output enable, no memory traffic
    base = rd_n;
    oe0  = oe_hi;
    start("ig");
    xfer(8'h0B, 8, 1'b0, rx, oe);
    for (int k = 0; k < 4; k++) begin
      xfer(8'h00, 8, k == 3, rx, oe);
      chk("ig_oe", oe, 8'h00);
    end
    finish_xact("ig");
    chk("ig_oe_cycles", oe_hi - oe0, 0);
    chk("ig_no_rd", rd_n - base, 0);

    // reset pulse in the middle of a data byte
    start("rr");
    send_read("rr", 24'h000040);
    xfer(8'h00, 8, 1'b0, rx, oe); chk("rr_b0", rx, 8'hE5);
    xfer(8'h00, 4, 1'b0, rx, oe); chk("rr_part", rx, 8'hE0);
    reset_n = 1'b0;
    #1;
    chk("rr_rst_oe", bus.spi_miso_oe_o, 1'b0);
    chk("rr_rst_miso", bus.spi_miso_o, 1'b0);
    chk("rr_rst_addr", bus.mem_addr_o, 16'h0000);
    chk("rr_rst_rd", bus.mem_rd_o, 1'b0);
    chk("rr_rst_busy", bus.busy_o, 1'b0);
    bus.spi_cs_n_i = 1'b1;
    #9;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    base = rd_n;
    start("ar");
    send_read("ar", 24'h000003);
    xfer(8'h00, 8, 1'b0, rx, oe); chk("ar_b0", rx, 8'hA6);
    xfer(8'h00, 8, 1'b1, rx, oe); chk("ar_b1", rx, 8'hA1);
    finish_xact("ar");
    chk_reads("ar", base, 3, 16'h0003);

    chk("miso_gated", miso_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
